// File: rtl/mem_port0_req_ctrl.sv
// Port-0 (1RW) request/response front-end for the interleaved SRAM array.
// Issues array accesses combinationally and returns read data in order through a credited FFT FIFO.
module mem_port0_req_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_ADDRESSES = 4096,
  parameter int unsigned RD_LATENCY    = 2,
  parameter int unsigned RSP_DEPTH     = 4
) (
  input  logic                             clk0,
  input  logic                             rst0,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [DATA_WIDTH/8-1:0]          req_wmask,
  input  logic [$clog2(NUM_ADDRESSES)-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             busy,
  output logic                             csb0,
  output logic                             web0,
  output logic [DATA_WIDTH/8-1:0]          wmask0,
  output logic [$clog2(NUM_ADDRESSES)-1:0] port0_address,
  output logic [DATA_WIDTH-1:0]            port0_datain,
  input  logic [DATA_WIDTH-1:0]            port0_dataout
);

  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic                  fire;
  logic                  rd_fire;
  logic                  push;
  logic                  pop;
  logic [RD_LATENCY-1:0] vld;
  logic [CW-1:0]         count;
  logic [CW-1:0]         inflight;
  logic [CW:0]           used;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(vld[i]);
    end
  end

  // Credit uses registered occupancy only; a same-cycle pop frees its slot next cycle.
  assign used      = {1'b0, count} + {1'b0, inflight};
  assign req_ready = ~rst0 & (req_we | (used < (CW+1)'(RSP_DEPTH)));

  assign fire          = req_valid & req_ready;
  assign rd_fire       = fire & ~req_we;
  assign csb0          = ~fire;
  assign web0          = ~(fire & req_we);
  assign wmask0        = (req_we & ~rst0) ? req_wmask : '0;
  assign port0_address = req_addr;
  assign port0_datain  = req_wdata;

  assign push      = vld[RD_LATENCY-1];
  assign pop       = rsp_ready & (count != '0);
  assign rsp_valid = (count != '0);
  assign rsp_rdata = mem[rd_ptr];
  assign busy      = (|vld) | (count != '0);

  always_ff @(posedge clk0) begin
    if (rst0) begin
      vld <= '0;
    end else begin
      vld <= RD_LATENCY'({vld, rd_fire});
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk0) begin
    if (push && !rst0) mem[wr_ptr] <= port0_dataout;
  end

  a_no_overflow: assert property (@(posedge clk0) disable iff (rst0)
    push |-> (count != CW'(RSP_DEPTH)));

endmodule

// File: tb/tb_mem_port0_req_ctrl.sv
// Bench for mem_port0_req_ctrl: behavioural SRAM array plus a queue-based
// reference of outstanding reads (data and availability cycle).
module tb_mem_port0_req_ctrl;

  localparam int DW = 32;
  localparam int NA = 4096;
  localparam int AW = 12;
  localparam int RL = 2;
  localparam int RD = 4;

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [3:0]    req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          csb0;
  logic          web0;
  logic [3:0]    wmask0;
  logic [AW-1:0] port0_address;
  logic [DW-1:0] port0_datain;
  logic [DW-1:0] port0_dataout;

  always #5 clk0 = ~clk0;

  mem_port0_req_ctrl #(
    .DATA_WIDTH(DW), .NUM_ADDRESSES(NA), .RD_LATENCY(RL), .RSP_DEPTH(RD)
  ) dut (
    .clk0(clk0), .rst0(rst0),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .port0_address(port0_address), .port0_datain(port0_datain),
    .port0_dataout(port0_dataout)
  );

  // Array initial contents: 0x123 starts at zero, every other word is tagged with its address.
  function automatic logic [DW-1:0] preload(input int a);
    return (a == 'h123) ? 32'h0 : (32'hA5A5_0000 | 32'(a));
  endfunction

  // Behavioural array: registered inputs, data valid RL edges after issue, junk otherwise.
  logic [DW-1:0] sram [int];
  logic [DW-1:0] pipe [RL];
  always @(posedge clk0) begin
    logic [DW-1:0] rd;
    logic [DW-1:0] w;
    int a;
    a  = int'(port0_address);
    rd = $urandom;
    if (!csb0) begin
      w = sram.exists(a) ? sram[a] : preload(a);
      if (!web0) begin
        for (int b = 0; b < 4; b++) if (wmask0[b]) w[8*b +: 8] = port0_datain[8*b +: 8];
        sram[a] = w;
      end else begin
        rd = w;
      end
    end
    pipe[0] <= rd;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign port0_dataout = pipe[RL-1];

  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] ref_mem [int];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : preload(int'(a));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [3:0] m,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic rr, input logic rst,
                      output logic dut_fire, output logic dut_pop);
    logic rdy_exp, vld_exp, fire_exp, pop_exp;
    logic [DW-1:0] w;
    @(negedge clk0);
    req_valid = v; req_we = we; req_wmask = m; req_addr = a; req_wdata = d;
    rsp_ready = rr; rst0 = rst;
    #1;
    rdy_exp  = !rst && (we || exp_q.size() < RD);
    vld_exp  = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    fire_exp = v && rdy_exp;
    pop_exp  = rr && vld_exp;
    check("req_ready", 32'(req_ready), 32'(rdy_exp));
    check("csb0", 32'(csb0), 32'(!fire_exp));
    check("web0", 32'(web0), 32'(!(fire_exp && we)));
    check("wmask0", 32'(wmask0), (we && !rst) ? 32'(m) : 32'h0);
    check("port0_address", 32'(port0_address), 32'(a));
    check("port0_datain", port0_datain, d);
    check("rsp_valid", 32'(rsp_valid), 32'(vld_exp));
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
    if (vld_exp) check("rsp_rdata", rsp_rdata, exp_q[0].data);
    dut_fire = v && req_ready;
    dut_pop  = rr && rsp_valid;
    @(posedge clk0);
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (pop_exp) void'(exp_q.pop_front());
      if (fire_exp && !we) exp_q.push_back('{data: ref_rd(a), avail: cyc + RL});
      if (fire_exp && we) begin
        w = ref_rd(a);
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[int'(a)] = w;
      end
    end
  endtask

  task automatic idle(input logic rr);
    logic f, p;
    step(1'b0, 1'b0, 4'h0, '0, '0, rr, 1'b0, f, p);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1);
    idle(1'b1);
    #1 check("drain_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    logic f, p;
    int acc, fires, pops;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 12'h010, '0, 1'b1, 1'b1, f, p);
    #1 check("reset_rsp_valid", 32'(rsp_valid), 32'h0);

    // Single read of preloaded word
    step(1'b1, 1'b0, 4'h0, 12'h010, '0, 1'b0, 1'b0, f, p);
    check("t1_accept", 32'(f), 32'h1);
    for (int i = 0; i < RL; i++) idle(1'b0);
    #1;
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rdata", rsp_rdata, 32'hA5A5_0010);
    drain();

    // Masked write then read back
    step(1'b1, 1'b1, 4'b0101, 12'h123, 32'hDEAD_BEEF, 1'b1, 1'b0, f, p);
    idle(1'b0);
    step(1'b1, 1'b0, 4'h0, 12'h123, '0, 1'b0, 1'b0, f, p);
    for (int i = 0; i < RL; i++) idle(1'b0);
    #1 check("t2_rdata", rsp_rdata, 32'h00AD_00EF);
    drain();

    // Credit limit with consumer stalled
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 4'h0, AW'(32'h200 + i), '0, 1'b0, 1'b0, f, p);
      acc += int'(f);
    end
    check("t3_accepted", 32'(acc), 32'd4);
    #1 check("t3_ready_low", 32'(req_ready), 32'h0);
    for (int i = 0; i < 40 && acc < 8; i++) begin
      step(1'b1, 1'b0, 4'h0, AW'(32'h200 + acc), '0, 1'b1, 1'b0, f, p);
      acc += int'(f);
    end
    check("t3_total", 32'(acc), 32'd8);
    drain();

    // Streaming throughput
    fires = 0; pops = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, 4'h0, AW'(32'h300 + i), '0, 1'b1, 1'b0, f, p);
      if (i >= 10) begin
        fires += int'(f);
        pops  += int'(p);
      end
    end
    check("t4_fires", 32'(fires), 32'd20);
    check("t4_pops", 32'(pops), 32'd20);
    drain();

    // Reset with reads in flight
    step(1'b1, 1'b0, 4'h0, 12'h011, '0, 1'b0, 1'b0, f, p);
    step(1'b1, 1'b0, 4'h0, 12'h012, '0, 1'b0, 1'b0, f, p);
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, 1'b1, f, p);
    #1;
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    step(1'b1, 1'b0, 4'h0, 12'h010, '0, 1'b0, 1'b0, f, p);
    for (int i = 0; i < RL; i++) idle(1'b0);
    #1 check("t5_rdata", rsp_rdata, 32'hA5A5_0010);
    drain();

    // Random mixed traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom),
           AW'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0,
           1'b0, f, p);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
